// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state IDLE/WAIT/DONE sequencer that holds a
// memory read for MEM_LATENCY cycles, captures the returned word and advances the PC.
// A jump target that arrives mid-fetch is parked in a one-entry pending register
// and is applied when the fetch completes.
// Optional feature: define FETCH_UNIT_COUNT_EN to get a saturating completed-fetch
// counter on fetch_count; otherwise fetch_count is tied to zero.
module fetch_unit #(
  parameter int unsigned MEM_LATENCY = 3,
  parameter logic [31:0] PC_RESET    = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_dout,
  output logic        mem_en,
  output logic        mem_ren,
  output logic [15:0] mem_addr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_done,
  output logic        busy,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state;
  logic [3:0]  wait_cnt;
  logic        pend_valid;
  logic [31:0] pend_pc;

  // Fetch sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      wait_cnt   <= 4'd0;
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
      mem_en     <= 1'b0;
      mem_ren    <= 1'b0;
      mem_addr   <= 16'd0;
      instr      <= 32'd0;
      pc         <= PC_RESET;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pc_load) begin
            pc <= pc_in;
          end
          if (fetch_req) begin
            // A simultaneous load redirects this very fetch.
            mem_addr <= pc_load ? pc_in[15:0] : pc[15:0];
            mem_en   <= 1'b1;
            mem_ren  <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= 4'(MEM_LATENCY);
            state    <= StWait;
          end
        end
        StWait: begin
          if (pc_load) begin
            pend_valid <= 1'b1;
            pend_pc    <= pc_in;
          end
          // Count 1 marks the last cycle of the memory access: data is valid now.
          if (wait_cnt == 4'd1) begin
            instr   <= mem_dout;
            mem_en  <= 1'b0;
            mem_ren <= 1'b0;
            state   <= StDone;
          end
          wait_cnt <= wait_cnt - 4'd1;
        end
        StDone: begin
          fetch_done <= 1'b1;
          busy       <= 1'b0;
          pend_valid <= 1'b0;
          state      <= StIdle;
          // A load arriving in this very cycle is the latest one and wins.
          if (pc_load) begin
            pc <= pc_in;
          end else if (pend_valid) begin
            pc <= pend_pc;
          end else begin
            pc <= pc + 32'd1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_UNIT_COUNT_EN
  // Completed-fetch counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
    end else if (state == StDone && fetch_count != 32'hFFFF_FFFF) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus,
// all compared against a transaction-level model of the fetch timeline.
module tb_fetch_unit;

  localparam int unsigned Lat     = 3;
  localparam logic [31:0] PcReset = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n, fetch_req, pc_load;
  logic [31:0] pc_in, mem_dout;
  logic        mem_en, mem_ren, fetch_done, busy;
  logic [15:0] mem_addr;
  logic [31:0] instr, pc, fetch_count;

  fetch_unit #(.MEM_LATENCY(Lat), .PC_RESET(PcReset)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
    .mem_dout(mem_dout), .mem_en(mem_en), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .instr(instr), .pc(pc), .fetch_done(fetch_done), .busy(busy), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: age = edges since the accepting edge (-1 when no fetch is in flight).
  int          m_age = -1;
  logic [31:0] m_pc = PcReset, m_instr = 0, m_pend = 0, m_count = 0;
  logic [15:0] m_addr = 0;
  logic        m_pend_v = 0, m_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic req, input logic ld,
                            input logic [31:0] pin, input logic [31:0] dout);
    if (!r) begin
      m_age = -1; m_pc = PcReset; m_instr = 0; m_addr = 0; m_done = 0;
      m_pend_v = 0; m_pend = 0; m_count = 0;
      return;
    end
    m_done = 0;
    if (m_age < 0) begin
      if (ld) m_pc = pin;
      if (req) begin
        m_addr = m_pc[15:0];
        m_age  = 0;
      end
    end else if (m_age == int'(Lat)) begin
      m_done = 1;
      m_pc   = ld ? pin : (m_pend_v ? m_pend : m_pc + 32'd1);
      m_pend_v = 0;
      m_age    = -1;
`ifdef FETCH_UNIT_COUNT_EN
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
`endif
    end else begin
      if (ld) begin
        m_pend_v = 1;
        m_pend   = pin;
      end
      if (m_age == int'(Lat) - 1) m_instr = dout;
      m_age++;
    end
  endtask

  task automatic check_all();
    logic act;
    act = (m_age >= 0) && (m_age < int'(Lat));
    check("mem_en", 32'(mem_en), 32'(act));
    check("mem_ren", 32'(mem_ren), 32'(act));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("instr", instr, m_instr);
    check("pc", pc, m_pc);
    check("fetch_done", 32'(fetch_done), 32'(m_done));
    check("busy", 32'(busy), 32'(m_age >= 0));
    check("fetch_count", fetch_count, m_count);
  endtask

  // One clock: drive inputs, clock the DUT and the model, compare just after the edge.
  task automatic step(input logic r, input logic req, input logic ld,
                      input logic [31:0] pin, input logic [31:0] dout);
    rst_n = r; fetch_req = req; pc_load = ld; pc_in = pin; mem_dout = dout;
    @(posedge clk);
    model_edge(r, req, ld, pin, dout);
    #1;
    check_all();
  endtask

  // Run until fetch_done; returns cycles taken and mem_ren-high cycles seen.
  task automatic run_done(input logic req_in_wait, input logic [31:0] dout,
                          output int n, output int ren_cnt);
    n = 0;
    ren_cnt = 0;
    while (n < 20) begin
      step(1'b1, req_in_wait, 1'b0, 32'd0, dout);
      n++;
      if (mem_ren) ren_cnt++;
      if (fetch_done) break;
    end
    if (!fetch_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  int n, rc;
  logic [31:0] exp_cnt;

  initial begin
    rst_n = 0; fetch_req = 0; pc_load = 0; pc_in = 0; mem_dout = 0;
    step(1'b0, 1'b1, 1'b1, 32'h1234, 32'hDEAD);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Basic fetch of mem[0].
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h0BAD_0BAD);
    run_done(1'b0, 32'h2008_0005, n, rc);
    check("latency", 32'(n + 1), 32'(Lat + 2));
    check("ren_cycles", 32'(rc + 1), 32'(Lat));
    check("instr_basic", instr, 32'h2008_0005);
    check("pc_basic", pc, 32'd1);

    // Load and fetch together.
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'd0);
    check("addr_load", 32'(mem_addr), 32'h0040);
    run_done(1'b0, 32'hCAFE_0040, n, rc);
    check("pc_load_fetch", pc, 32'h41);

    // Two loads during WAIT: fetch unaffected, last load wins.
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h20, 32'd0);
    run_done(1'b0, 32'h0000_0041, n, rc);
    check("instr_old_pc", instr, 32'h0000_0041);
    check("pc_pending", pc, 32'h20);

    // PC wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    check("addr_wrap", 32'(mem_addr), 32'hFFFF);
    run_done(1'b0, 32'h5A5A_5A5A, n, rc);
    check("pc_wrap", pc, 32'd0);

    // Reset in the second WAIT cycle aborts the fetch.
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'h7777_7777);
    step(1'b0, 1'b1, 1'b1, 32'h99, 32'h7777_7777);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, PcReset);
    check("rst_en", 32'(mem_en), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'h7777_7777);
      check("no_late_done", 32'(fetch_done), 32'd0);
    end

    // Four back-to-back fetches, with ignored requests during the first two.
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int f = 0; f < 4; f++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
      run_done(f < 2, 32'(f), n, rc);
    end
`ifdef FETCH_UNIT_COUNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    check("count4", fetch_count, exp_cnt);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 5) == 0, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 3, which sets the memory read latency in cycles (legal range 1..15).
REQ-002 SHALL have parameter PC_RESET, default 32'd0, which sets the PC value after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port fetch_req, input, 1 bit: request to fetch the instruction at the current PC.
REQ-006 SHALL have port pc_load, input, 1 bit: load a new PC value from jump or branch.
REQ-007 SHALL have port pc_in, input, 32 bits: the target PC used with pc_load.
REQ-008 SHALL have port mem_dout, input, 32 bits: the memory read data.
REQ-009 SHALL have ports mem_en and mem_ren, each output, 1 bit: memory enable and memory read enable.
REQ-010 SHALL have port mem_addr, output, 16 bits: the memory word address, equal to pc[15:0] at request.
REQ-011 SHALL have port instr, output, 32 bits: the fetched instruction, held until the next completed fetch.
REQ-012 SHALL have port pc, output, 32 bits: the current PC, word-addressed.
REQ-013 SHALL have port fetch_done, output, 1 bit: a one-cycle pulse that marks instr as valid.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port fetch_count, output, 32 bits: the number of completed fetches (see Configuration).

Function
REQ-016 SHALL implement states IDLE, WAIT and DONE, with all outputs registered.
REQ-017 SHALL, in IDLE with fetch_req=1 at an edge, go to WAIT, set mem_en=mem_ren=1, drive mem_addr=pc[15:0] and load the wait counter with MEM_LATENCY.
REQ-018 SHALL keep mem_en and mem_ren high for exactly MEM_LATENCY cycles while in WAIT, decrementing the counter once per cycle.
REQ-019 SHALL, when the counter reaches its final count, capture mem_dout into instr, drop mem_en/mem_ren and go to DONE.
REQ-020 SHALL, in DONE, assert fetch_done for exactly one cycle, update pc (see REQ-022) and return to IDLE on the next edge.
REQ-021 SHALL hold the total latency at MEM_LATENCY+2 cycles, measured from the edge that samples fetch_req to the first cycle in which fetch_done is high.
REQ-022 SHALL, in DONE, set pc to pc+1 with 32-bit modular wrap (0xFFFFFFFF->0x00000000), unless a deferred load is pending.
REQ-023 SHALL, for pc_load=1 in IDLE, set pc=pc_in at that edge.
REQ-024 SHALL, if pc_load and fetch_req are both high in IDLE, fetch from pc_in and drive mem_addr=pc_in[15:0].
REQ-025 SHALL, for pc_load=1 in WAIT or DONE, latch pc_in into a one-entry pending register; the in-flight fetch completes unchanged and DONE sets pc to the pending value instead of pc+1.
REQ-026 SHALL let a later pc_load overwrite a pending load; the last value wins.
REQ-027 SHALL ignore fetch_req while in WAIT or DONE; it is neither queued nor counted.
REQ-028 SHALL ignore mem_dout outside the capture cycle.

Reset
REQ-029 SHALL, on rst_n=0 at an edge, set state=IDLE, pc=PC_RESET, instr=0, mem_en=mem_ren=0, mem_addr=0, fetch_done=0, busy=0, clear the pending load and set fetch_count=0.
REQ-030 SHALL abort an in-flight fetch on reset without updating instr and without pulsing fetch_done.
REQ-031 SHALL give reset priority over fetch_req and pc_load in the same cycle.

Configuration
REQ-032 SHALL, with macro FETCH_UNIT_COUNT_EN defined, increment fetch_count by 1 on each DONE cycle, saturating at 0xFFFFFFFF.
REQ-033 SHALL, without FETCH_UNIT_COUNT_EN, tie fetch_count to 32'd0 and generate no counter logic.

Verification
REQ-034 SHALL cover: reset, then fetch_req pulse, MEM_LATENCY=3, mem[0]=0x20080005 -> mem_ren high for 3 cycles, fetch_done pulses 5 cycles after the request edge, instr=0x20080005, pc=1.
REQ-035 SHALL cover: pc_load with pc_in=0x40 plus fetch_req in the same IDLE cycle -> mem_addr=0x0040, and after completion pc=0x41.
REQ-036 SHALL cover: pc_load with pc_in=0x10 during WAIT, then pc_load with pc_in=0x20 -> instr is still from the old PC, and after DONE pc=0x20.
REQ-037 SHALL cover: pc=0xFFFFFFFF, then a fetch -> mem_addr=0xFFFF, and after DONE pc=0x00000000.
REQ-038 SHALL cover: rst_n=0 in the second WAIT cycle -> no fetch_done pulse, instr=0, pc=PC_RESET, mem_en=0 on the next cycle.
REQ-039 SHALL cover: with FETCH_UNIT_COUNT_EN defined, 4 back-to-back fetches plus 2 fetch_req pulses during WAIT -> fetch_count=4; without the macro, fetch_count=0.
